// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU load/store port and a secondary (DMA/debug) master.
// Latency: each access holds the memory for ACCESS_CYCLES cycles after a one-cycle IDLE grant; dma_ack is registered one edge later.
// Backpressure: the CPU is stalled via cpu_ready; the secondary master holds dma_req until dma_ack. Round-robin on contention.
//
// Ports:
//   clk, rst                                 - single clock, synchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_rdata/ready   - CPU MIO port (level request, cpu_ready = MIO_ready)
//   dma_req/we/addr/wdata, dma_rdata/ack     - secondary master req/ack port
//   mem_addr/wdata/we, mem_rdata             - single-port data memory (word addressed)
//   busy, owner, cpu_stall_cnt               - status and performance debug
module dmem_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [31:0]       cpu_stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       lat_we;
  logic       dma_req_eff;
  logic       grant_vld;
  logic       grant_dma;
  logic       done;

  // Byte-lane bits and bits above the memory index are dropped, so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              dma_addr[31:ADDR_W+2], dma_addr[1:0]};

  // During the ack cycle the requester is still holding the old request level.
  assign dma_req_eff = dma_req & ~dma_ack;
  assign grant_vld   = (state == IDLE) & (cpu_req | dma_req_eff);
  // On contention owner names the previous winner, so the other side gets it.
  assign grant_dma   = dma_req_eff & (~cpu_req | ~owner);
  assign done        = (state == BUSY) & (cnt == 4'd0);
  assign busy        = (state == BUSY);
  assign cpu_rdata   = mem_rdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        cpu_ready = ~cpu_req;
      end else begin
        cpu_ready = done & ~owner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      owner         <= 1'b1;
      lat_we        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      dma_ack       <= 1'b0;
      dma_rdata     <= '0;
      cpu_stall_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // Write strobe lives only in the first BUSY cycle.
      mem_we  <= 1'b0;
      dma_ack <= done & owner;
      if (grant_vld) begin
        owner     <= grant_dma;
        lat_we    <= grant_dma ? dma_we : cpu_we;
        mem_we    <= grant_dma ? dma_we : cpu_we;
        mem_addr  <= grant_dma ? dma_addr[ADDR_W+1:2] : cpu_addr[ADDR_W+1:2];
        mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
      end
      if (done && owner && !lat_we) begin
        dma_rdata <= mem_rdata;
      end
      if (cpu_req && !cpu_ready && (cpu_stall_cnt != 32'hFFFF_FFFF)) begin
        cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus a randomized two-master run checked against a memory scoreboard.
// Latency: compares exact cycle counts in directed tests and round-robin wait bounds in the random test.
// Backpressure: masters hold requests until cpu_ready / dma_ack, exactly as the real requesters would.
module tb_dmem_arbiter;

  localparam int AC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // Main instance (ACCESS_CYCLES = 2)
  logic        rst, cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata, cpu_stall_cnt;
  logic        cpu_ready, dma_ack, mem_we, busy, owner;
  logic [9:0]  mem_addr;

  // Second instance (ACCESS_CYCLES = 1), CPU port only
  logic        rst_b, cpu_req_b, cpu_we_b;
  logic [31:0] cpu_addr_b, cpu_wdata_b, cpu_rdata_b, mem_wdata_b, mem_rdata_b, cpu_stall_cnt_b;
  logic        cpu_ready_b, mem_we_b;
  logic [9:0]  mem_addr_b;
  logic [31:0] unused_dma_rdata_b;
  logic        unused_dma_ack_b, unused_busy_b, unused_owner_b;

  dmem_arbiter #(.ADDR_W(10), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner), .cpu_stall_cnt(cpu_stall_cnt)
  );

  dmem_arbiter #(.ADDR_W(10), .ACCESS_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst_b),
    .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
    .cpu_rdata(cpu_rdata_b), .cpu_ready(cpu_ready_b),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_rdata(unused_dma_rdata_b), .dma_ack(unused_dma_ack_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .mem_rdata(mem_rdata_b),
    .busy(unused_busy_b), .owner(unused_owner_b), .cpu_stall_cnt(cpu_stall_cnt_b)
  );

  // Memories: asynchronous read, write on the clock edge; preload port writes both.
  logic [31:0] mem1 [0:1023];
  logic [31:0] mem2 [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_dat = '0;

  always @(posedge clk) begin
    if (mem_we) mem1[mem_addr] <= mem_wdata;
    if (mem_we_b) mem2[mem_addr_b] <= mem_wdata_b;
    if (pl_en) begin
      mem1[pl_addr] <= pl_dat;
      mem2[pl_addr] <= pl_dat;
    end
  end
  assign mem_rdata   = mem1[mem_addr];
  assign mem_rdata_b = mem2[mem_addr_b];

  // Free-running count of write strobes seen by the memory.
  int n_strobes = 0;
  always @(negedge clk) if (mem_we) n_strobes++;

  logic [31:0] ref_mem [0:15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    cpu_req_b = 0; cpu_we_b = 0; cpu_addr_b = 0; cpu_wdata_b = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; rst_b = 1;
    tick(); tick();
    rst = 0; rst_b = 0;
  endtask

  // One CPU access on the main instance; records the cpu_ready pattern and write strobes.
  task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output logic [7:0] pat, output int ncyc,
                            output int nwe, output logic [9:0] we_addr);
    pat = '0; ncyc = 0; nwe = 0; we_addr = '0; rd = '0;
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ncyc++;
      pat = {pat[6:0], cpu_ready};
      if (mem_we) begin
        nwe++;
        we_addr = mem_addr;
      end
      if (cpu_ready) begin
        rd = cpu_rdata;
        break;
      end
    end
    tick();
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; rst_b = 1;
    tick();
    @(negedge clk);
    n_run++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready: got %b, expected 0", cpu_ready); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    n_run++; if (owner !== 1'b1) begin n_fail++; $display("FAIL reset_owner: got %b, expected 1", owner); end
    n_run++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b, expected 0", mem_we); end
    n_run++; if (mem_addr !== 10'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h, expected 0", mem_addr); end
    n_run++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h, expected 0", mem_wdata); end
    n_run++; if (dma_ack !== 1'b0) begin n_fail++; $display("FAIL reset_dma_ack: got %b, expected 0", dma_ack); end
    n_run++; if (dma_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_dma_rdata: got %h, expected 0", dma_rdata); end
    n_run++; if (cpu_stall_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d, expected 0", cpu_stall_cnt); end
    n_run++; if (cpu_ready_b !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready_b: got %b, expected 0", cpu_ready_b); end
    tick();
    rst = 0; rst_b = 0;
    @(negedge clk);
    n_run++; if (cpu_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cpu_ready: got %b, expected 1", cpu_ready); end
    tick();
  endtask

  task automatic test_cpu_wr_rd();
    logic [31:0] rd;
    logic [7:0]  pat;
    int          ncyc, nwe;
    logic [9:0]  wa;
    do_reset();
    cpu_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, rd, pat, ncyc, nwe, wa);
    n_run++; if (pat !== 8'b001 || ncyc !== 3) begin n_fail++; $display("FAIL wr_ready_pattern: got %b over %0d cycles, expected 001 over 3", pat, ncyc); end
    n_run++; if (nwe !== 1) begin n_fail++; $display("FAIL wr_strobe_count: got %0d, expected 1", nwe); end
    n_run++; if (wa !== 10'h004) begin n_fail++; $display("FAIL wr_mem_addr: got %h, expected 004", wa); end
    cpu_access(1'b0, 32'h0000_0010, 32'h0, rd, pat, ncyc, nwe, wa);
    n_run++; if (pat !== 8'b001 || ncyc !== 3) begin n_fail++; $display("FAIL rd_ready_pattern: got %b over %0d cycles, expected 001 over 3", pat, ncyc); end
    n_run++; if (nwe !== 0) begin n_fail++; $display("FAIL rd_strobe_count: got %0d, expected 0", nwe); end
    n_run++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h, expected deadbeef", rd); end
    n_run++; if (cpu_stall_cnt !== 32'd4) begin n_fail++; $display("FAIL stall_cnt: got %0d, expected 4", cpu_stall_cnt); end
  endtask

  task automatic test_dma_read();
    int          ack_cyc;
    logic [31:0] got;
    do_reset();
    preload(10'd7, 32'h1234_5678);
    for (int pass = 0; pass < 2; pass++) begin
      // pass 0 reads word 7; pass 1 writes word 8 and must leave dma_rdata alone
      ack_cyc = 0; got = '0;
      dma_req = 1; dma_we = (pass == 1); dma_addr = (pass == 1) ? 32'h20 : 32'h1C; dma_wdata = 32'h5555_AAAA;
      for (int i = 1; i <= 12; i++) begin
        @(negedge clk);
        if (dma_ack) begin
          ack_cyc = i;
          got = dma_rdata;
          break;
        end
      end
      n_run++; if (ack_cyc !== 4) begin n_fail++; $display("FAIL dma_ack_cycle[%0d]: got %0d, expected 4", pass, ack_cyc); end
      n_run++; if (got !== 32'h1234_5678) begin n_fail++; $display("FAIL dma_rdata[%0d]: got %h, expected 12345678", pass, got); end
      tick();
      dma_req = 0; dma_we = 0;
      @(negedge clk);
      n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dma_no_regrant[%0d]: busy got %b, expected 0", pass, busy); end
      n_run++; if (dma_ack !== 1'b0) begin n_fail++; $display("FAIL dma_ack_pulse[%0d]: got %b, expected 0", pass, dma_ack); end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    logic q[$];
    logic prev;
    do_reset();
    prev = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
    dma_req = 1; dma_we = 0; dma_addr = 32'h24;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy && !prev) q.push_back(owner);
      prev = busy;
    end
    tick();
    idle_inputs();
    n_run++; if (q.size() !== 10) begin n_fail++; $display("FAIL sim_grant_count: got %0d, expected 10", q.size()); end
    for (int k = 0; k < q.size(); k++) begin
      n_run++;
      if (q[k] !== k[0]) begin n_fail++; $display("FAIL sim_grant_order[%0d]: got owner %b, expected %b", k, q[k], k[0]); end
    end
  endtask

  task automatic test_reset_mid();
    int acks;
    do_reset();
    dma_req = 1; dma_we = 0; dma_addr = 32'h1C;
    tick();
    rst = 1;
    @(negedge clk);
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_first_busy: got %b, expected 1", busy); end
    n_run++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_cpu_ready_in_rst: got %b, expected 0", cpu_ready); end
    tick();
    rst = 0; dma_req = 0;
    @(negedge clk);
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: busy got %b, expected 0", busy); end
    n_run++; if (owner !== 1'b1) begin n_fail++; $display("FAIL mid_owner: got %b, expected 1", owner); end
    n_run++; if (mem_addr !== 10'h0 || mem_we !== 1'b0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL mid_mem_outputs: got addr %h we %b wdata %h, expected 0 0 0", mem_addr, mem_we, mem_wdata); end
    n_run++; if (dma_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_dma_rdata: got %h, expected 0", dma_rdata); end
    acks = dma_ack ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dma_ack) acks++;
    end
    n_run++; if (acks !== 0) begin n_fail++; $display("FAIL mid_no_ack: got %0d ack cycles, expected 0", acks); end
    tick();
  endtask

  task automatic test_misaligned();
    logic [31:0] rd;
    logic [7:0]  pat;
    int          ncyc, nwe;
    logic [9:0]  wa;
    do_reset();
    cpu_access(1'b1, 32'hFFFF_F013, 32'hA5A5_0001, rd, pat, ncyc, nwe, wa);
    n_run++; if (nwe !== 1 || wa !== 10'h004) begin n_fail++; $display("FAIL misaligned_addr: got %0d strobes at %h, expected 1 at 004", nwe, wa); end
    cpu_access(1'b0, 32'h0000_0010, 32'h0, rd, pat, ncyc, nwe, wa);
    n_run++; if (rd !== 32'hA5A5_0001) begin n_fail++; $display("FAIL misaligned_alias: got %h, expected a5a50001", rd); end
  endtask

  task automatic test_ac1();
    logic [7:0]  pat;
    logic [31:0] rd;
    int          ncyc;
    do_reset();
    preload(10'd3, 32'hCAFE_0003);
    pat = '0; ncyc = 0; rd = '0;
    cpu_req_b = 1; cpu_we_b = 0; cpu_addr_b = 32'h0C;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ncyc++;
      pat = {pat[6:0], cpu_ready_b};
      if (cpu_ready_b) begin
        rd = cpu_rdata_b;
        break;
      end
    end
    tick();
    cpu_req_b = 0;
    n_run++; if (pat !== 8'b01 || ncyc !== 2) begin n_fail++; $display("FAIL ac1_ready_pattern: got %b over %0d cycles, expected 01 over 2", pat, ncyc); end
    n_run++; if (rd !== 32'hCAFE_0003) begin n_fail++; $display("FAIL ac1_rdata: got %h, expected cafe0003", rd); end
    n_run++; if (cpu_stall_cnt_b !== 32'd1) begin n_fail++; $display("FAIL ac1_stall_cnt: got %0d, expected 1", cpu_stall_cnt_b); end
  endtask

  // Random traffic from both masters. The model: memory is an array updated in completion
  // order, and round-robin bounds each wait to at most one foreign access.
  int n_wr_issued;

  task automatic cpu_master(input int n);
    logic [31:0] r, wd;
    logic [3:0]  idx;
    logic        we;
    int          ncyc;
    logic [31:0] rd;
    logic        seen;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 2) != 0) begin
        cpu_req = 0;
        repeat ($urandom_range(1, 3)) tick();
      end
      r = $urandom; wd = $urandom; idx = 4'($urandom_range(0, 15)); we = r[5];
      cpu_req = 1; cpu_we = we; cpu_wdata = wd;
      cpu_addr = {r[31:12], 6'b0, idx, r[1:0]};
      ncyc = 0; seen = 0; rd = '0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        ncyc++;
        if (cpu_ready) begin
          seen = 1;
          rd = cpu_rdata;
          break;
        end
      end
      n_run++;
      if (!seen || ncyc < AC + 1 || ncyc > 2 * (AC + 1)) begin
        n_fail++; $display("FAIL rnd_cpu_latency[%0d]: got %0d cycles (done=%b), expected %0d..%0d", t, ncyc, seen, AC + 1, 2 * (AC + 1));
      end
      if (we) begin
        ref_mem[idx] = wd;
        n_wr_issued++;
      end else begin
        n_run++;
        if (rd !== ref_mem[idx]) begin n_fail++; $display("FAIL rnd_cpu_rdata[%0d]: got %h, expected %h", t, rd, ref_mem[idx]); end
      end
      tick();
    end
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic dma_master(input int n);
    logic [31:0] r, wd;
    logic [3:0]  idx;
    logic        we;
    int          ncyc;
    logic [31:0] rd;
    logic        seen;
    for (int t = 0; t < n; t++) begin
      if ($urandom_range(0, 2) != 0) begin
        dma_req = 0;
        repeat ($urandom_range(1, 3)) tick();
      end
      r = $urandom; wd = $urandom; idx = 4'($urandom_range(0, 15)); we = r[7];
      dma_req = 1; dma_we = we; dma_wdata = wd;
      dma_addr = {r[31:12], 6'b0, idx, r[1:0]};
      ncyc = 0; seen = 0; rd = '0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        ncyc++;
        if (dma_ack) begin
          seen = 1;
          rd = dma_rdata;
          break;
        end
      end
      n_run++;
      if (!seen || ncyc < AC + 2 || ncyc > 2 * (AC + 1) + 1) begin
        n_fail++; $display("FAIL rnd_dma_latency[%0d]: got %0d cycles (ack=%b), expected %0d..%0d", t, ncyc, seen, AC + 2, 2 * (AC + 1) + 1);
      end
      if (we) begin
        ref_mem[idx] = wd;
        n_wr_issued++;
      end else begin
        n_run++;
        if (rd !== ref_mem[idx]) begin n_fail++; $display("FAIL rnd_dma_rdata[%0d]: got %h, expected %h", t, rd, ref_mem[idx]); end
      end
      tick();
    end
    dma_req = 0; dma_we = 0;
  endtask

  task automatic test_random();
    int strobes0;
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      preload(10'(i), v);
    end
    n_wr_issued = 0;
    strobes0 = n_strobes;
    fork
      cpu_master(25);
      dma_master(25);
    join
    repeat (2 * (AC + 2)) tick();
    n_run++;
    if (n_strobes - strobes0 !== n_wr_issued) begin
      n_fail++; $display("FAIL rnd_write_strobes: got %0d, expected %0d", n_strobes - strobes0, n_wr_issued);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1; rst_b = 1;
    tick();
    test_reset();
    test_cpu_wr_rd();
    test_dma_read();
    test_simultaneous();
    test_reset_mid();
    test_misaligned();
    test_ac1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the SCPU load/store port and a secondary bus master (DMA/debug loader). It sits between the CPU's `Addr_out`/`Data_out`/`MemRW`/`Data_in`/`MIO_ready` pins and the data memory. It stalls the CPU through `cpu_ready` while the memory is busy and serves the secondary master with a req/ack handshake. Round-robin priority guarantees that neither master starves; a saturating counter records CPU stall cycles for performance debug.

## Interface
- `ADDR_W`, 10, word-address width driven to memory; the index is byte address bits [ADDR_W+1:2].
- `ACCESS_CYCLES`, 2, cycles the memory address is held per access; legal range 1..15.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU access request (CPU_MIO); level, held with stable fields until `cpu_ready`.
- `cpu_we` in 1: CPU write (MemRW).
- `cpu_addr` in 32: CPU byte address.
- `cpu_wdata` in 32: CPU store data.
- `cpu_rdata` out 32: load data to CPU; combinational copy of `mem_rdata`.
- `cpu_ready` out 1: to CPU `MIO_ready`; low stalls the CPU.
- `dma_req` in 1: secondary request; level, held with stable fields until `dma_ack`.
- `dma_we` in 1: secondary write.
- `dma_addr` in 32: secondary byte address.
- `dma_wdata` in 32: secondary store data.
- `dma_rdata` out 32: registered read data; valid while `dma_ack` is high and held until the next DMA completion.
- `dma_ack` out 1: registered one-cycle completion pulse.
- `mem_addr` out ADDR_W: word address to memory.
- `mem_wdata` out 32: write data to memory.
- `mem_we` out 1: memory write strobe.
- `mem_rdata` in 32: memory read data.
- `busy` out 1: high in BUSY.
- `owner` out 1: current or last grant (0 = CPU, 1 = DMA).
- `cpu_stall_cnt` out 32: saturating count of cycles with `cpu_req` high and `cpu_ready` low.

## Operation
- FSM states:
  - IDLE:
    - Either request present → grant it, latch we/addr/wdata, load `cnt = ACCESS_CYCLES-1`, go to BUSY.
    - No request → stay in IDLE.
  - BUSY:
    - `cnt != 0` → decrement and stay.
    - `cnt == 0` → completion cycle; go to IDLE.
- Arbitration:
  - Only one requester → grant it.
  - Both requesting → grant the master not granted last (round-robin via `owner`).
- DMA ack cycle:
  - `dma_req` is ignored in any cycle where `dma_ack` is high, because the requester cannot yet have dropped it.
  - A request seen in the following cycle is a new transfer.
- Memory drive in BUSY:
  - `mem_addr` and `mem_wdata` come from the latched fields and are stable for all BUSY cycles.
  - `mem_we` is high only in the first BUSY cycle, and only for a write grant.
  - In IDLE, `mem_we` = 0 and `mem_addr`/`mem_wdata` hold their last values.
- Memory contract: `mem_rdata` is valid in the completion cycle when the address has been held for ACCESS_CYCLES cycles.
- `cpu_ready` decode:
  - In IDLE: `cpu_ready = ~cpu_req`.
  - In BUSY: `cpu_ready` = 1 only in the completion cycle of a CPU grant, else 0.
- CPU read data: `cpu_rdata` is sampled by the CPU on the completion edge.
- DMA completion: on the completion edge of a DMA grant, `dma_rdata` ← `mem_rdata` (reads only; writes leave it unchanged) and `dma_ack` ← 1 for one cycle.
- Address alignment: byte-address bits [1:0] are ignored; bits above ADDR_W+1 are ignored and wrap.
- `cpu_stall_cnt` increments when `cpu_req & ~cpu_ready` and saturates at 0xFFFFFFFF.

## Timing
- CPU access issued in IDLE with no contention: `cpu_ready` is low for ACCESS_CYCLES cycles, then high for 1 cycle. That is ACCESS_CYCLES+1 cycles from request to completion edge.
- DMA access: `dma_ack` rises ACCESS_CYCLES+1 cycles after the first cycle `dma_req` is seen in IDLE.
- Contention: the losing master waits one full access (ACCESS_CYCLES+1 cycles) plus its own access.
- Back-to-back: every access passes through IDLE, so the minimum issue interval is ACCESS_CYCLES+1 cycles.
- Simultaneous new requests in the same IDLE cycle: resolved by round-robin; the loser's request stays pending and is never dropped.
- Reset values:
  - state IDLE, `cnt` 0, `owner` 1 (CPU wins the first contention).
  - `mem_we`, `mem_addr`, `mem_wdata` 0.
  - `dma_ack` 0, `dma_rdata` 0, `cpu_stall_cnt` 0, `busy` 0.
  - `cpu_ready` 0 while `rst` is high.
- Reset mid-access: the transfer is abandoned next edge, with no `dma_ack` and no completion. A write may already have been strobed.

## Test plan
- **CPU write then read** (ACCESS_CYCLES=2): CPU stores 0xDEADBEEF to 0x0000_0010, then loads it. Required:
  - `mem_we` high 1 cycle with `mem_addr` = 4.
  - `cpu_ready` pattern 0,0,1 per access.
  - `cpu_rdata` = 0xDEADBEEF at the load completion.
  - `cpu_stall_cnt` = 4.
- **DMA read**: DMA reads word 7 preloaded with 0x12345678. Required: `dma_ack` high in the 4th cycle after `dma_req` rises, with `dma_rdata` = 0x12345678; `dma_req` held through the ack produces no second grant.
- **Simultaneous requests after reset**: CPU and DMA request together. Required: CPU is granted first, DMA second. Repeat with both requests held continuously: grants alternate CPU, DMA, CPU, DMA.
- **ACCESS_CYCLES=1**: CPU load. Required: `cpu_ready` pattern 0,1 and `cpu_stall_cnt` = 1.
- **Reset mid-access**: assert `rst` in the first BUSY cycle of a DMA read. Required: the next cycle is IDLE, `dma_ack` stays 0, and all outputs hold their reset values.
- **Misaligned and high address**: CPU address 0xFFFF_F013. Required: `mem_addr` = 0x004 (bits [11:2]).
